// File: rtl/ccu_window_monitor_if.sv
// Result port of the window monitor: delta/alarm/overrun with a valid/ready handshake.
// The producer (monitor) uses the master modport; the downstream consumer uses slave.
interface ccu_window_monitor_if;
  logic [7:0] delta;
  logic       out_valid;
  logic       out_ready;
  logic       alarm;
  logic       overrun;

  modport master (
    output delta,
    output out_valid,
    output alarm,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  delta,
    input  out_valid,
    input  alarm,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/ccu_window_monitor.sv
// Samples the running equal-pair count every WIN cycles and reports the per-window increment.
// Define CCU_MON_OVERWRITE_EN to replace a pending result on overrun instead of dropping the new one.
module ccu_window_monitor #(
  parameter int unsigned WIN    = 16,
  parameter int unsigned THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           z,
  ccu_window_monitor_if.master mon
);

  localparam int unsigned     CW    = $clog2(WIN);
  localparam logic [CW-1:0]   WLAST = CW'(WIN - 1);
  localparam logic [7:0]      TH    = 8'(THRESH);

  typedef enum logic [1:0] {
    S_INIT,
    S_COUNT,
    S_PEND
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [7:0]    z_base, z_base_nx;
  logic [7:0]    delta_q, delta_nx;
  logic          valid_q, valid_nx;
  logic          alarm_q, alarm_nx;
  logic          ovr_q, ovr_nx;
  logic [7:0]    diff;
  logic          win_end;

  // Modulo-256 difference handles counter wrap-around for free.
  assign diff    = z - z_base;
  assign win_end = (wcnt == WLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      wcnt    <= '0;
      z_base  <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      z_base  <= z_base_nx;
      delta_q <= delta_nx;
      valid_q <= valid_nx;
      alarm_q <= alarm_nx;
      ovr_q   <= ovr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wcnt_nx   = win_end ? '0 : wcnt + CW'(1);
    z_base_nx = z_base;
    delta_nx  = delta_q;
    valid_nx  = valid_q;
    alarm_nx  = alarm_q;
    ovr_nx    = ovr_q;

    case (state)
      S_INIT: begin
        wcnt_nx   = '0;
        z_base_nx = z;
        state_nx  = S_COUNT;
      end
      S_COUNT: begin
        if (win_end) begin
          delta_nx  = diff;
          alarm_nx  = (diff >= TH);
          z_base_nx = z;
          valid_nx  = 1'b1;
          state_nx  = S_PEND;
        end
      end
      S_PEND: begin
        if (win_end) begin
          // The window always closes; only what happens to the new result depends on ready.
          z_base_nx = z;
          if (mon.out_ready) begin
            delta_nx = diff;
            alarm_nx = (diff >= TH);
          end else begin
            ovr_nx = 1'b1;
`ifdef CCU_MON_OVERWRITE_EN
            delta_nx = diff;
            alarm_nx = (diff >= TH);
`endif
          end
        end else if (mon.out_ready) begin
          valid_nx = 1'b0;
          state_nx = S_COUNT;
        end
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase
  end

  assign mon.delta     = delta_q;
  assign mon.out_valid = valid_q;
  assign mon.alarm     = alarm_q;
  assign mon.overrun   = ovr_q;

endmodule

// File: tb/tb_ccu_window_monitor.sv
// Directed bench for ccu_window_monitor (WIN=16, THRESH=4) with a queue-based result scoreboard.
module tb_ccu_window_monitor;

  typedef struct packed {
    logic [7:0] d;
    logic       a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] z = 8'h00;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t mon_e;

  ccu_window_monitor_if ifc ();

  ccu_window_monitor #(
    .WIN   (16),
    .THRESH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .z    (z),
    .mon  (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got delta %0h with no expected result", ifc.delta);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_delta", {24'h0, ifc.delta}, {24'h0, mon_e.d});
        chk("sb_alarm", {31'h0, ifc.alarm}, {31'h0, mon_e.a});
      end
    end
  end

  initial begin
    // Reset behaviour and first-window latency
    ifc.out_ready = 1'b1;
    z = 8'h05;
    tick(3);
    chk("rst_delta",   {24'h0, ifc.delta},     32'h0);
    chk("rst_valid",   {31'h0, ifc.out_valid}, 32'h0);
    chk("rst_alarm",   {31'h0, ifc.alarm},     32'h0);
    chk("rst_overrun", {31'h0, ifc.overrun},   32'h0);
    rst_n = 1'b1;
    tick(1);                      // S_INIT edge: base = 0x05
    z = 8'h08;
    sbq.push_back('{d: 8'd3, a: 1'b0});
    tick(15);
    chk("w1_not_yet", {31'h0, ifc.out_valid}, 32'h0);
    tick(1);
    chk("w1_valid", {31'h0, ifc.out_valid}, 32'h1);
    chk("w1_delta", {24'h0, ifc.delta},     32'h3);
    tick(1);
    chk("w1_one_cycle", {31'h0, ifc.out_valid}, 32'h0);

    // Wrap-around: base climbs to 0xFE, then the count wraps to 0x03
    z = 8'hFE;
    sbq.push_back('{d: 8'hF6, a: 1'b1});
    tick(15);
    chk("w2_valid", {31'h0, ifc.out_valid}, 32'h1);
    z = 8'h03;
    sbq.push_back('{d: 8'd5, a: 1'b1});
    tick(16);
    chk("wrap_delta", {24'h0, ifc.delta}, 32'h5);
    chk("wrap_alarm", {31'h0, ifc.alarm}, 32'h1);
    tick(1);

    // Back-pressure across two window ends (deltas 2 then 7)
    ifc.out_ready = 1'b0;
    z = 8'h05;
`ifndef CCU_MON_OVERWRITE_EN
    sbq.push_back('{d: 8'd2, a: 1'b0});
`endif
    tick(15);
    chk("bp_first_valid", {31'h0, ifc.out_valid}, 32'h1);
    chk("bp_no_ovr_yet",  {31'h0, ifc.overrun},   32'h0);
    z = 8'h0C;
`ifdef CCU_MON_OVERWRITE_EN
    sbq.push_back('{d: 8'd7, a: 1'b1});
`endif
    tick(16);
    chk("bp_overrun", {31'h0, ifc.overrun},   32'h1);
    chk("bp_valid",   {31'h0, ifc.out_valid}, 32'h1);
`ifdef CCU_MON_OVERWRITE_EN
    chk("bp_delta", {24'h0, ifc.delta}, 32'h7);
    chk("bp_alarm", {31'h0, ifc.alarm}, 32'h1);
`else
    chk("bp_delta", {24'h0, ifc.delta}, 32'h2);
    chk("bp_alarm", {31'h0, ifc.alarm}, 32'h0);
`endif

    // Mid-operation asynchronous reset at wcnt = 9 with a result pending
    tick(9);
    chk("pre_rst_overrun", {31'h0, ifc.overrun},   32'h1);
    chk("pre_rst_valid",   {31'h0, ifc.out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_delta",   {24'h0, ifc.delta},     32'h0);
    chk("arst_valid",   {31'h0, ifc.out_valid}, 32'h0);
    chk("arst_alarm",   {31'h0, ifc.alarm},     32'h0);
    chk("arst_overrun", {31'h0, ifc.overrun},   32'h0);
    sbq.delete();
    z = 8'h20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);                      // S_INIT edge: base = 0x20
    z = 8'h21;
    sbq.push_back('{d: 8'd1, a: 1'b0});
    tick(15);
    chk("rr_not_yet", {31'h0, ifc.out_valid}, 32'h0);
    tick(1);
    chk("rr_valid", {31'h0, ifc.out_valid}, 32'h1);
    chk("rr_delta", {24'h0, ifc.delta},     32'h1);

    // Transfer on the same edge as the next window end
    z = 8'h2A;
    sbq.push_back('{d: 8'd9, a: 1'b1});
    tick(15);
    ifc.out_ready = 1'b1;
    tick(1);
    chk("sim_valid",   {31'h0, ifc.out_valid}, 32'h1);
    chk("sim_delta",   {24'h0, ifc.delta},     32'h9);
    chk("sim_alarm",   {31'h0, ifc.alarm},     32'h1);
    chk("sim_overrun", {31'h0, ifc.overrun},   32'h0);
    tick(1);
    chk("sim_drained", {31'h0, ifc.out_valid}, 32'h0);
    tick(2);
    chk("sb_empty", sbq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
